// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter and its lane encoder.
package mem_arb_pkg;

  localparam int unsigned LANE_W = 4;
  localparam int unsigned RMEM_W = 5;

  // RISC-V load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RISC-V store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Read code for a full unsigned word (fetch and LW)
  localparam logic [RMEM_W-1:0] RMEM_WORD = 5'b01111;

  // Who owns the response slot in the cycle after a grant
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2,
    OWN_DERR = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals around mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12
);

  logic              if_req_valid;
  logic              if_req_ready;
  logic [31:0]       if_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_inst;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_we;
  logic [2:0]        d_funct3;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              d_err;

  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_wmem;
  logic [4:0]        m_rmem;
  logic [31:0]       m_store_data;
  logic [31:0]       m_load_data;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr,
    input  d_req_valid, d_we, d_funct3, d_addr, d_wdata,
    input  m_load_data,
    output if_req_ready, if_rsp_valid, if_rsp_inst,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_err,
    output m_addr, m_wmem, m_rmem, m_store_data
  );

  // Pipeline and memory side
  modport master (
    output if_req_valid, if_addr,
    output d_req_valid, d_we, d_funct3, d_addr, d_wdata,
    output m_load_data,
    input  if_req_ready, if_rsp_valid, if_rsp_inst,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_err,
    input  m_addr, m_wmem, m_rmem, m_store_data
  );

endinterface

// File: rtl/mem_lane_enc.sv
// Combinational funct3 + byte-offset to memory lane-code encoder with
// misalignment/illegal-opcode detection. Erroring accesses produce all-zero codes.
module mem_lane_enc
  import mem_arb_pkg::*;
(
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [1:0]        a,
  output logic [LANE_W-1:0] wmem,
  output logic [RMEM_W-1:0] rmem,
  output logic              err
);

  logic [LANE_W-1:0] lane;
  logic              sgn;
  logic              illegal;
  logic              misal;

  // Decode size, lane mask, sign and error conditions
  always_comb begin
    lane    = '0;
    sgn     = 1'b0;
    illegal = 1'b0;
    misal   = 1'b0;
    if (we) begin
      case (funct3)
        F3_SB: lane = 4'b0001 << a;
        F3_SH: begin
          lane  = 4'b0011 << {a[1], 1'b0};
          misal = a[0];
        end
        F3_SW: begin
          lane  = 4'b1111;
          misal = |a;
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_LB: begin
          lane = 4'b0001 << a;
          sgn  = 1'b1;
        end
        F3_LH: begin
          lane  = 4'b0011 << {a[1], 1'b0};
          sgn   = 1'b1;
          misal = a[0];
        end
        F3_LW: begin
          lane  = 4'b1111;
          misal = |a;
        end
        F3_LBU: lane = 4'b0001 << a;
        F3_LHU: begin
          lane  = 4'b0011 << {a[1], 1'b0};
          misal = a[0];
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  // Suppress both codes for erroring requests so nothing reaches memory
  always_comb begin
    err  = illegal | misal;
    wmem = '0;
    rmem = '0;
    if (!err) begin
      if (we) wmem = lane;
      else    rmem = {sgn, lane};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single synchronous-read memory port between fetch and load/store.
// Data has priority; with MEM_ARB_FAIRNESS_EN defined, fetch is forced through
// after STARVE_MAX consecutive data grants while it waits.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  logic              enc_err;
  logic [LANE_W-1:0] enc_wmem;
  logic [RMEM_W-1:0] enc_rmem;

  logic              fetch_turn;
  logic              grant_d;
  logic              grant_if;

  owner_e            owner_q, owner_d;
  logic              store_q, store_d;

  mem_lane_enc u_lane_enc (
    .we     (bus.d_we),
    .funct3 (bus.d_funct3),
    .a      (bus.d_addr[1:0]),
    .wmem   (enc_wmem),
    .rmem   (enc_rmem),
    .err    (enc_err)
  );

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q, starve_d;

  // Fetch wins once data has taken STARVE_MAX grants in a row while fetch waited
  assign fetch_turn = bus.if_req_valid && (starve_q == CNT_W'(STARVE_MAX));

  // Count data grants that made fetch wait; any fetch grant clears the count
  always_comb begin
    starve_d = starve_q;
    if (grant_if)
      starve_d = '0;
    else if (grant_d && bus.if_req_valid)
      starve_d = starve_q + CNT_W'(1);
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  // Strict data priority; STARVE_MAX has no effect in this build
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign fetch_turn        = 1'b0;
`endif

  // Address bits outside the word index (fetch offset is aligned by contract)
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.d_addr[31:ADDR_W+2]};

  // Grant selection, memory-port drive and next response owner
  always_comb begin
    grant_d      = bus.d_req_valid && !fetch_turn;
    grant_if     = bus.if_req_valid && !grant_d;
    owner_d      = OWN_NONE;
    store_d      = 1'b0;
    bus.m_addr   = '0;
    bus.m_wmem   = '0;
    bus.m_rmem   = '0;
    if (grant_d) begin
      if (enc_err) begin
        owner_d = OWN_DERR;
      end else begin
        owner_d    = OWN_D;
        store_d    = bus.d_we;
        bus.m_addr = bus.d_addr[ADDR_W+1:2];
        bus.m_wmem = enc_wmem;
        bus.m_rmem = enc_rmem;
      end
    end else if (grant_if) begin
      owner_d    = OWN_IF;
      bus.m_addr = bus.if_addr[ADDR_W+1:2];
      bus.m_rmem = RMEM_WORD;
    end
  end

  // Response owner register; reset drops any outstanding response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      store_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      store_q <= store_d;
    end
  end

  assign bus.if_req_ready = grant_if;
  assign bus.d_req_ready  = grant_d;
  assign bus.m_store_data = bus.d_wdata;

  // Route the one-cycle-late memory data back to whoever was granted
  assign bus.if_rsp_valid = (owner_q == OWN_IF);
  assign bus.if_rsp_inst  = (owner_q == OWN_IF) ? bus.m_load_data : 32'd0;
  assign bus.d_rsp_valid  = (owner_q == OWN_D) || (owner_q == OWN_DERR);
  assign bus.d_err        = (owner_q == OWN_DERR);
  assign bus.d_rsp_data   = ((owner_q == OWN_D) && !store_q) ? bus.m_load_data : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous-read memory model.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  mem_arbiter_if #(.ADDR_W(12)) bus ();

  mem_arbiter #(.ADDR_W(12), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: lane writes and extracted/sign-extended reads, 1-cycle latency
  logic [31:0] mem [0:4095];
  logic [31:0] ld_q;
  assign bus.m_load_data = ld_q;

  always @(posedge clk) begin
    int          sh;
    int          n;
    logic [31:0] w;
    logic [31:0] v;
    if (bus.m_wmem != 4'b0000) begin
      sh = 0;
      while (!bus.m_wmem[sh]) sh++;
      w = bus.m_store_data << (8 * sh);
      for (int i = 0; i < 4; i++)
        if (bus.m_wmem[i]) mem[bus.m_addr][8*i +: 8] = w[8*i +: 8];
    end
    if (bus.m_rmem[3:0] != 4'b0000) begin
      sh = 0;
      n  = 0;
      while (!bus.m_rmem[sh]) sh++;
      for (int i = 0; i < 4; i++) if (bus.m_rmem[i]) n++;
      v = mem[bus.m_addr] >> (8 * sh);
      if (n == 1)      v = bus.m_rmem[4] ? {{24{v[7]}}, v[7:0]}   : {24'd0, v[7:0]};
      else if (n == 2) v = bus.m_rmem[4] ? {{16{v[15]}}, v[15:0]} : {16'd0, v[15:0]};
      ld_q <= v;
    end
  end

  task automatic idle();
    bus.if_req_valid = 1'b0;
    bus.if_addr      = 32'd0;
    bus.d_req_valid  = 1'b0;
    bus.d_we         = 1'b0;
    bus.d_funct3     = 3'b000;
    bus.d_addr       = 32'd0;
    bus.d_wdata      = 32'd0;
  endtask

  task automatic drive_d(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.d_req_valid = 1'b1;
    bus.d_we        = we;
    bus.d_funct3    = f3;
    bus.d_addr      = a;
    bus.d_wdata     = wd;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if (bus.if_rsp_valid !== 1'b0) $display("FAIL reset_if_rsp_valid: got %b want 0", bus.if_rsp_valid); else n_pass++;
    n_total++; if (bus.d_rsp_valid !== 1'b0) $display("FAIL reset_d_rsp_valid: got %b want 0", bus.d_rsp_valid); else n_pass++;
    n_total++; if ({bus.if_req_ready, bus.d_req_ready, bus.d_err} !== 3'b000) $display("FAIL reset_ready_err: got %b want 000", {bus.if_req_ready, bus.d_req_ready, bus.d_err}); else n_pass++;
    n_total++; if ({bus.m_addr, bus.m_wmem, bus.m_rmem} !== 21'd0) $display("FAIL reset_mport: got addr %h wmem %b rmem %b want 0", bus.m_addr, bus.m_wmem, bus.m_rmem); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_load_byte();
    @(posedge clk); #1 drive_d(1'b0, 3'b000, 32'h0000_0102, 32'd0);
    @(negedge clk);
    n_total++; if (bus.d_req_ready !== 1'b1) $display("FAIL lb_ready: got %b want 1", bus.d_req_ready); else n_pass++;
    n_total++; if (bus.m_rmem !== 5'b10100) $display("FAIL lb_rmem: got %b want 10100", bus.m_rmem); else n_pass++;
    n_total++; if (bus.m_addr !== 12'h040) $display("FAIL lb_addr: got %h want 040", bus.m_addr); else n_pass++;
    n_total++; if (bus.m_wmem !== 4'b0000) $display("FAIL lb_wmem: got %b want 0000", bus.m_wmem); else n_pass++;
    @(posedge clk); #1 idle();
    @(negedge clk);
    n_total++; if ({bus.d_rsp_valid, bus.d_err} !== 2'b10) $display("FAIL lb_rsp_valid: got %b want 10", {bus.d_rsp_valid, bus.d_err}); else n_pass++;
    n_total++; if (bus.d_rsp_data !== 32'hFFFF_FFFF) $display("FAIL lb_data: got %h want ffffffff", bus.d_rsp_data); else n_pass++;
    n_total++; if (bus.if_rsp_valid !== 1'b0) $display("FAIL lb_no_if_rsp: got %b want 0", bus.if_rsp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1 drive_d(1'b1, 3'b001, 32'h0000_0006, 32'h0000_BEEF);
    @(negedge clk);
    n_total++; if (bus.m_wmem !== 4'b1100) $display("FAIL sh_wmem: got %b want 1100", bus.m_wmem); else n_pass++;
    n_total++; if ({bus.m_rmem, bus.m_addr} !== {5'b00000, 12'h001}) $display("FAIL sh_rmem_addr: got %b %h want 00000 001", bus.m_rmem, bus.m_addr); else n_pass++;
    n_total++; if (bus.m_store_data !== 32'h0000_BEEF) $display("FAIL sh_store_data: got %h want 0000beef", bus.m_store_data); else n_pass++;
    @(posedge clk); #1 drive_d(1'b0, 3'b101, 32'h0000_0006, 32'd0);
    @(negedge clk);
    n_total++; if ({bus.d_rsp_valid, bus.d_err, bus.d_rsp_data} !== {2'b10, 32'd0}) $display("FAIL sh_ack: got %b%b %h want 10 00000000", bus.d_rsp_valid, bus.d_err, bus.d_rsp_data); else n_pass++;
    n_total++; if ({bus.d_req_ready, bus.m_rmem} !== 6'b1_01100) $display("FAIL lhu_issue: got %b %b want 1 01100", bus.d_req_ready, bus.m_rmem); else n_pass++;
    @(posedge clk); #1 idle();
    @(negedge clk);
    n_total++; if ({bus.d_rsp_valid, bus.d_rsp_data} !== {1'b1, 32'h0000_BEEF}) $display("FAIL lhu_data: got %b %h want 1 0000beef", bus.d_rsp_valid, bus.d_rsp_data); else n_pass++;
  endtask

  task automatic test_errors();
    @(posedge clk); #1 drive_d(1'b0, 3'b010, 32'h0000_000A, 32'd0);
    @(negedge clk);
    n_total++; if (bus.d_req_ready !== 1'b1) $display("FAIL lw_mis_ready: got %b want 1", bus.d_req_ready); else n_pass++;
    n_total++; if ({bus.m_rmem, bus.m_wmem} !== 9'd0) $display("FAIL lw_mis_mport: got %b %b want 0", bus.m_rmem, bus.m_wmem); else n_pass++;
    @(posedge clk); #1 drive_d(1'b1, 3'b100, 32'h0000_0000, 32'h1111_1111);
    @(negedge clk);
    n_total++; if ({bus.d_rsp_valid, bus.d_err, bus.d_rsp_data} !== {2'b11, 32'd0}) $display("FAIL lw_mis_rsp: got %b%b %h want 11 00000000", bus.d_rsp_valid, bus.d_err, bus.d_rsp_data); else n_pass++;
    n_total++; if ({bus.d_req_ready, bus.m_wmem} !== 5'b1_0000) $display("FAIL st_illegal_issue: got %b %b want 1 0000", bus.d_req_ready, bus.m_wmem); else n_pass++;
    @(posedge clk); #1 drive_d(1'b0, 3'b011, 32'h0000_0000, 32'd0);
    @(negedge clk);
    n_total++; if ({bus.d_rsp_valid, bus.d_err} !== 2'b11) $display("FAIL st_illegal_rsp: got %b want 11", {bus.d_rsp_valid, bus.d_err}); else n_pass++;
    n_total++; if (bus.m_rmem !== 5'b00000) $display("FAIL ld_f3_011_rmem: got %b want 00000", bus.m_rmem); else n_pass++;
    @(posedge clk); #1 idle();
    @(negedge clk);
    n_total++; if (bus.d_err !== 1'b1) $display("FAIL ld_f3_011_err: got %b want 1", bus.d_err); else n_pass++;
    n_total++; if (mem[0] !== 32'h0000_0013) $display("FAIL illegal_store_wrote: got %h want 00000013", mem[0]); else n_pass++;
  endtask

  task automatic test_fetch();
    @(posedge clk); #1 bus.if_req_valid = 1'b1; bus.if_addr = 32'h0000_0010;
    @(negedge clk);
    n_total++; if ({bus.if_req_ready, bus.d_req_ready} !== 2'b10) $display("FAIL if_ready: got %b want 10", {bus.if_req_ready, bus.d_req_ready}); else n_pass++;
    n_total++; if ({bus.m_rmem, bus.m_wmem, bus.m_addr} !== {5'b01111, 4'b0000, 12'h004}) $display("FAIL if_mport: got %b %b %h want 01111 0000 004", bus.m_rmem, bus.m_wmem, bus.m_addr); else n_pass++;
    @(posedge clk); #1 idle();
    @(negedge clk);
    n_total++; if ({bus.if_rsp_valid, bus.d_rsp_valid} !== 2'b10) $display("FAIL if_rsp_valid: got %b want 10", {bus.if_rsp_valid, bus.d_rsp_valid}); else n_pass++;
    n_total++; if (bus.if_rsp_inst !== 32'h1234_5678) $display("FAIL if_inst: got %h want 12345678", bus.if_rsp_inst); else n_pass++;
  endtask

  task automatic test_contention();
    logic [5:0] exp_d;
    logic [5:0] exp_if;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_d = 6'b101111;
`else
    exp_d = 6'b111111;
`endif
    exp_if = ~exp_d;
    @(posedge clk); #1
    bus.if_req_valid = 1'b1;
    bus.if_addr      = 32'h0000_0010;
    drive_d(1'b0, 3'b010, 32'h0000_0000, 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_total++;
      if ({bus.d_req_ready, bus.if_req_ready} !== {exp_d[c], exp_if[c]})
        $display("FAIL contention_cycle%0d: got d/if %b%b want %b%b", c, bus.d_req_ready, bus.if_req_ready, exp_d[c], exp_if[c]);
      else n_pass++;
      @(posedge clk);
    end
    #1 idle();
    @(negedge clk);
    n_total++; if (bus.d_rsp_valid !== exp_d[5]) $display("FAIL contention_last_rsp: got %b want %b", bus.d_rsp_valid, exp_d[5]); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    @(posedge clk); #1 bus.if_req_valid = 1'b1; bus.if_addr = 32'h0000_0010;
    @(posedge clk); #1 idle(); rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (bus.if_rsp_valid !== 1'b0) $display("FAIL rst_mid_in_reset: got %b want 0", bus.if_rsp_valid); else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_total++; if ({bus.if_rsp_valid, bus.d_rsp_valid} !== 2'b00) $display("FAIL rst_mid_after_release: got %b want 00", {bus.if_rsp_valid, bus.d_rsp_valid}); else n_pass++;
    @(posedge clk); #1 bus.if_req_valid = 1'b1; bus.if_addr = 32'h0000_0000;
    @(negedge clk);
    n_total++; if (bus.if_req_ready !== 1'b1) $display("FAIL rst_mid_refetch_ready: got %b want 1", bus.if_req_ready); else n_pass++;
    @(posedge clk); #1 idle();
    @(negedge clk);
    n_total++; if ({bus.if_rsp_valid, bus.if_rsp_inst} !== {1'b1, 32'h0000_0013}) $display("FAIL rst_mid_refetch: got %b %h want 1 00000013", bus.if_rsp_valid, bus.if_rsp_inst); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    ld_q    = 32'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    mem[0]     = 32'h0000_0013;
    mem[4]     = 32'h1234_5678;
    mem[12'h040] = 32'h80FF_1234;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_byte();
    test_back_to_back();
    test_errors();
    test_fetch();
    test_contention();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
